alu32: RTL and testbench

ALU32 -- requirements
Module: alu32

---
 rtl/alu32_pkg.sv | 39 +++
 rtl/alu32_add_sub.sv | 40 ++++
 rtl/alu32.sv | 99 +++++++++
 tb/tb_alu32.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu32_pkg.sv
// -----------------------------------------------------------------------------
// alu32_pkg -- shared definitions for the 32-bit ALU and its control unit.
//
// Contents:
//   ALU_WIDTH   default data path width (only 32 is supported)
//   OPRN_W      width of the operation code bus (bit 5 is don't-care)
//   OPC_W       width of the decoded part of the operation code
//   opcode_e    operation codes, OP_ADD (0x01) .. OP_SLT (0x09)
//   fa_sum /    single-bit full adder helpers used by the ripple-carry
//   fa_carry    add/subtract unit
// -----------------------------------------------------------------------------
package alu32_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned OPRN_W    = 6;
    localparam int unsigned OPC_W     = 5;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 5'h00,
        OP_ADD = 5'h01,
        OP_SUB = 5'h02,
        OP_MUL = 5'h03,
        OP_SRL = 5'h04,
        OP_SLL = 5'h05,
        OP_AND = 5'h06,
        OP_OR  = 5'h07,
        OP_NOR = 5'h08,
        OP_SLT = 5'h09
    } opcode_e;

    function automatic logic fa_sum(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic ci);
        return (a & b) | (ci & (a ^ b));
    endfunction

endpackage

// File: rtl/alu32_add_sub.sv
// -----------------------------------------------------------------------------
// rc_add_sub_32 -- 32-bit ripple-carry adder/subtractor.
//
// Ports:
//   A    in  32  operand 1
//   B    in  32  operand 2
//   SnA  in   1  0 = add (A + B), 1 = subtract (A - B)
//   Y    out 32  sum / difference, modulo 2^32
//   CO   out  1  carry out of bit 31 (for subtract: 1 = no borrow)
//
// Subtraction is A + ~B + 1: B is inverted bit-wise and SnA doubles as the
// carry-in of the least significant full adder.
// -----------------------------------------------------------------------------
module rc_add_sub_32
    import alu32_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        SnA,
    output logic [31:0] Y,
    output logic        CO
);

    // The carry chain is walked with a procedural variable so the 32 full
    // adders ripple in one combinational block without a feedback vector.
    always_comb begin : ripple
        logic c;
        logic b_eff;
        Y     = '0;
        c     = SnA;
        b_eff = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            b_eff = B[i] ^ SnA;
            Y[i]  = fa_sum(A[i], b_eff, c);
            c     = fa_carry(A[i], b_eff, c);
        end
        CO = c;
    end

endmodule

// File: rtl/alu32.sv
// -----------------------------------------------------------------------------
// alu32 -- 32-bit registered ALU, one result per clock, latency 1 cycle.
//
// Ports:
//   CLK   in   1  clock, all state updates on the rising edge
//   RST   in   1  asynchronous active-low reset (Y = 0, ZERO = 1)
//   A     in  32  operand 1
//   B     in  32  operand 2, also the shift amount
//   OPRN  in   6  operation code; only OPRN[4:0] is decoded
//   Y     out 32  registered result
//   ZERO  out  1  registered flag, 1 when Y is all zeros
//
// Operations (OPRN[4:0]): 01 ADD, 02 SUB, 03 MUL, 04 SRL, 05 SLL, 06 AND,
// 07 OR, 08 NOR, 09 SLT (signed); every other code yields 0.
//
// Configuration macro ALU32_MUL_EN: when defined, code 03 returns the low
// 32 bits of the unsigned product; when undefined no multiplier is built and
// code 03 falls through to the unknown-code result (0).
// -----------------------------------------------------------------------------
module alu32
    import alu32_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
)(
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [OPRN_W-1:0]  OPRN,
    output logic [WIDTH-1:0]   Y,
    output logic               ZERO
);

    logic [OPC_W-1:0] opc;
    logic             unused_oprn5;
    logic             unused_co;
    logic             sub_sel;
    logic [WIDTH-1:0] addsub_y;
    logic             shift_oor;
    logic             slt_ovf;
    logic             slt_lt;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   out_q;

    // OPRN[5] never reaches the decoder, so 0, 1 or X there cannot change
    // the result.
    assign opc          = OPRN[OPC_W-1:0];
    assign unused_oprn5 = OPRN[OPRN_W-1];

    // SLT reuses the subtractor: A < B (signed) is the sign of A - B,
    // corrected when the subtraction overflows.
    assign sub_sel = (opc == OP_SUB) || (opc == OP_SLT);

    rc_add_sub_32 u_add_sub (
        .A   (A),
        .B   (B),
        .SnA (sub_sel),
        .Y   (addsub_y),
        .CO  (unused_co)
    );

    assign slt_ovf = (A[WIDTH-1] ^ B[WIDTH-1]) & (addsub_y[WIDTH-1] ^ A[WIDTH-1]);
    assign slt_lt  = addsub_y[WIDTH-1] ^ slt_ovf;

    // Shift amounts of 32 or more clear the result instead of wrapping.
    assign shift_oor = |B[WIDTH-1:5];

    always_comb begin
        result = '0;
        case (opc)
            OP_ADD,
            OP_SUB: result = addsub_y;
`ifdef ALU32_MUL_EN
            OP_MUL: result = A * B;
`endif
            OP_SRL: result = shift_oor ? '0 : (A >> B[4:0]);
            OP_SLL: result = shift_oor ? '0 : (A << B[4:0]);
            OP_AND: result = A & B;
            OP_OR:  result = A | B;
            OP_NOR: result = ~(A | B);
            OP_SLT: result = {{(WIDTH-1){1'b0}}, slt_lt};
            default: result = '0;
        endcase
    end

    // Single output register holding {ZERO, Y}; ZERO is derived from the
    // value being loaded so it is never a cycle behind Y.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_q <= {1'b1, {WIDTH{1'b0}}};
        end else begin
            out_q <= {~|result, result};
        end
    end

    assign ZERO = out_q[WIDTH];
    assign Y    = out_q[WIDTH-1:0];

endmodule

// File: tb/tb_alu32.sv
module tb_alu32;

    logic        CLK;
    logic        RST;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  OPRN;
    logic [31:0] Y;
    logic        ZERO;

    int n_cmp  = 0;
    int n_fail = 0;

    alu32 #(.WIDTH(32)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .A    (A),
        .B    (B),
        .OPRN (OPRN),
        .Y    (Y),
        .ZERO (ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] y;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    // Reference model: arithmetic straight from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] op);
        longint unsigned la, lb, two32;
        la    = longint'(a);
        lb    = longint'(b);
        two32 = 64'h1_0000_0000;
        case (int'(op % 32))
            1: return 32'((la + lb) % two32);
            2: return 32'((la + two32 - lb) % two32);
`ifdef ALU32_MUL_EN
            3: return 32'((la * lb) % two32);
`endif
            4: return (lb >= 32) ? 32'd0 : 32'(la / (64'd1 << lb));
            5: return (lb >= 32) ? 32'd0 : 32'((la * (64'd1 << lb)) % two32);
            6: return a & b;
            7: return a | b;
            8: return ~(a | b);
            9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        @(negedge CLK);
        A    = a;
        B    = b;
        OPRN = op;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb, ey;
        logic [5:0]  rop;

        vecs.push_back('{"add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 6'h01, 32'h0000_0000, 1'b1});
        vecs.push_back('{"sub_neg",   32'd5,         32'd7,         6'h02, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"slt_true",  32'hFFFF_FFFF, 32'h0000_0001, 6'h09, 32'd1,         1'b0});
        vecs.push_back('{"slt_false", 32'h0000_0001, 32'hFFFF_FFFF, 6'h09, 32'd0,         1'b1});
        vecs.push_back('{"sll_31",    32'h0000_0001, 32'd31,        6'h05, 32'h8000_0000, 1'b0});
        vecs.push_back('{"srl_32",    32'h8000_0000, 32'd32,        6'h04, 32'h0000_0000, 1'b1});
        vecs.push_back('{"srl_31",    32'h8000_0000, 32'd31,        6'h04, 32'h0000_0001, 1'b0});
        vecs.push_back('{"sll_big",   32'hFFFF_FFFF, 32'h0000_0100, 6'h05, 32'h0000_0000, 1'b1});
        vecs.push_back('{"nor_zero",  32'h0,         32'h0,         6'h08, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"op_2a",     32'h1234_5678, 32'h9ABC_DEF0, 6'h2A, 32'h0000_0000, 1'b1});
        vecs.push_back('{"op_00",     32'h1234_5678, 32'h9ABC_DEF0, 6'h00, 32'h0000_0000, 1'b1});
        vecs.push_back('{"and",       32'hF0F0_F0F0, 32'hFF00_FF00, 6'h06, 32'hF000_F000, 1'b0});
        vecs.push_back('{"or",        32'h0F0F_0000, 32'h0000_00F0, 6'h07, 32'h0F0F_00F0, 1'b0});
        vecs.push_back('{"add_bit5",  32'd2,         32'd3,         6'h21, 32'd5,         1'b0});
`ifdef ALU32_MUL_EN
        vecs.push_back('{"mul",       32'h0001_0000, 32'h0001_0003, 6'h03, 32'h0003_0000, 1'b0});
`else
        vecs.push_back('{"mul_off",   32'h0001_0000, 32'h0001_0003, 6'h03, 32'h0000_0000, 1'b1});
`endif

        // Reset asserted asynchronously, checked before any clock edge.
        RST  = 1'b1;
        A    = $urandom();
        B    = $urandom();
        OPRN = 6'h01;
        #2;
        RST = 1'b0;
        #1;
        check("rst_async_y", Y, 32'h0);
        check("rst_async_z", {31'd0, ZERO}, 32'd1);
        repeat (2) begin
            @(negedge CLK);
            A    = $urandom();
            B    = $urandom();
            OPRN = 6'($urandom_range(1, 9));
        end
        @(posedge CLK);
        #1;
        check("rst_hold_y", Y, 32'h0);
        check("rst_hold_z", {31'd0, ZERO}, 32'd1);
        @(negedge CLK);
        RST = 1'b1;

        // Directed vector table, one vector per cycle back to back.
        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].op);
            check({vecs[i].name, "_y"}, Y, vecs[i].y);
            check({vecs[i].name, "_z"}, {31'd0, ZERO}, {31'd0, vecs[i].z});
        end

        // Reset mid-stream discards the pending result; first edge after
        // release loads a fresh result.
        apply(32'd1, 32'd1, 6'h01);
        check("pre_rst_y", Y, 32'd2);
        @(negedge CLK);
        A    = 32'd3;
        B    = 32'd4;
        OPRN = 6'h01;
        #2;
        RST = 1'b0;
        #1;
        check("mid_rst_y", Y, 32'h0);
        check("mid_rst_z", {31'd0, ZERO}, 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_y", Y, 32'd7);
        check("post_rst_z", {31'd0, ZERO}, 32'd0);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 300; i++) begin
            ra  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            rb  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            rop = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) rb = ra;
            apply(ra, rb, rop);
            ey = ref_alu(ra, rb, rop);
            check("rand_y", Y, ey);
            check("rand_z", {31'd0, ZERO}, {31'd0, (ey == 32'd0)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
